// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write, issue and read signals of the two-write-port register file
interface regfile_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  RegWrite_a;
    logic [ADDR_WIDTH-1:0] Write_register_a;
    logic [DATA_WIDTH-1:0] Write_data_a;
    logic                  RegWrite_b;
    logic [ADDR_WIDTH-1:0] Write_register_b;
    logic [DATA_WIDTH-1:0] Write_data_b;
    logic                  Issue;
    logic [ADDR_WIDTH-1:0] Issue_register;
    logic [ADDR_WIDTH-1:0] Read_register1;
    logic [ADDR_WIDTH-1:0] Read_register2;
    logic [DATA_WIDTH-1:0] Read_data1;
    logic [DATA_WIDTH-1:0] Read_data2;
    logic                  Busy1;
    logic                  Busy2;

    modport master (
        output RegWrite_a, Write_register_a, Write_data_a,
        output RegWrite_b, Write_register_b, Write_data_b,
        output Issue, Issue_register, Read_register1, Read_register2,
        input  Read_data1, Read_data2, Busy1, Busy2
    );

    modport slave (
        input  RegWrite_a, Write_register_a, Write_data_a,
        input  RegWrite_b, Write_register_b, Write_data_b,
        input  Issue, Issue_register, Read_register1, Read_register2,
        output Read_data1, Read_data2, Busy1, Busy2
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: two-write-port register file with combinational reads, optional write bypass and pending scoreboard
module regfile_mp #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    SP_INDEX   = 29,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h3fc,
    parameter bit                    BYPASS     = 1'b1
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];
    logic [DEPTH-1:1]      pending;
    logic [ADDR_WIDTH-1:0] wr_a, wr_b;
    logic [DATA_WIDTH-1:0] wd_a, wd_b;
    logic                  commit_a, commit_b, bypass_on;

    assign wr_a      = bus.Write_register_a;
    assign wr_b      = bus.Write_register_b;
    assign wd_a      = bus.Write_data_a;
    assign wd_b      = bus.Write_data_b;
    assign commit_a  = bus.RegWrite_a && wr_a != '0;
    assign commit_b  = bus.RegWrite_b && wr_b != '0;
    assign bypass_on = BYPASS && reset;

    // Returns {busy, data}; a bypass hit means the value is available now, so busy drops.
    function automatic logic [DATA_WIDTH:0] read_port(input logic [ADDR_WIDTH-1:0] r);
        logic hit_a, hit_b;
        hit_a = bypass_on && commit_a && wr_a == r;
        hit_b = bypass_on && commit_b && wr_b == r;
        return (r == '0) ? '0 :
               hit_b     ? {1'b0, wd_b} :
               hit_a     ? {1'b0, wd_a} :
                           {pending[r], regs[r]};
    endfunction

    // Register storage: port B is written last so it wins a same-index conflict.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 1; i < DEPTH; i++)
                regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
        end else begin
            if (commit_a) regs[wr_a] <= wd_a;
            if (commit_b) regs[wr_b] <= wd_b;
        end
    end

    // Scoreboard: a committing write clears, a new issue sets and overrides the clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if ((commit_a && wr_a == ADDR_WIDTH'(i)) || (commit_b && wr_b == ADDR_WIDTH'(i)))
                    pending[i] <= 1'b0;
                if (bus.Issue && bus.Issue_register == ADDR_WIDTH'(i))
                    pending[i] <= 1'b1;
            end
        end
    end

    // Two independent combinational read ports.
    always_comb begin
        {bus.Busy1, bus.Read_data1} = read_port(bus.Read_register1);
        {bus.Busy2, bus.Read_data2} = read_port(bus.Read_register2);
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench running three configurations of regfile_mp against a reference model
module tb_regfile_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        wea = 1'b0, web = 1'b0, iss = 1'b0;
    logic [4:0]  wra = '0, wrb = '0, isr = '0, rr1 = '0, rr2 = '0;
    logic [31:0] wda = '0, wdb = '0;

    regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if1 ();
    regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if0 ();
    regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if4 ();

    assign if1.RegWrite_a = wea; assign if1.Write_register_a = wra; assign if1.Write_data_a = wda;
    assign if1.RegWrite_b = web; assign if1.Write_register_b = wrb; assign if1.Write_data_b = wdb;
    assign if1.Issue = iss; assign if1.Issue_register = isr;
    assign if1.Read_register1 = rr1; assign if1.Read_register2 = rr2;

    assign if0.RegWrite_a = wea; assign if0.Write_register_a = wra; assign if0.Write_data_a = wda;
    assign if0.RegWrite_b = web; assign if0.Write_register_b = wrb; assign if0.Write_data_b = wdb;
    assign if0.Issue = iss; assign if0.Issue_register = isr;
    assign if0.Read_register1 = rr1; assign if0.Read_register2 = rr2;

    assign if4.RegWrite_a = wea; assign if4.Write_register_a = wra[3:0]; assign if4.Write_data_a = wda;
    assign if4.RegWrite_b = web; assign if4.Write_register_b = wrb[3:0]; assign if4.Write_data_b = wdb;
    assign if4.Issue = iss; assign if4.Issue_register = isr[3:0];
    assign if4.Read_register1 = rr1[3:0]; assign if4.Read_register2 = rr2[3:0];

    regfile_mp #(.BYPASS(1'b1)) u_byp (.clk(clk), .reset(rst), .bus(if1));
    regfile_mp #(.BYPASS(1'b0)) u_nob (.clk(clk), .reset(rst), .bus(if0));
    regfile_mp #(.ADDR_WIDTH(4), .SP_INDEX(3), .BYPASS(1'b1)) u_a4 (.clk(clk), .reset(rst), .bus(if4));

    // Reference model: per configuration, an array of register values and pending flags.
    int          cfg_byp [3] = '{1, 0, 1};
    int          cfg_aw  [3] = '{5, 5, 4};
    int          cfg_sp  [3] = '{29, 29, 3};
    logic [31:0] mem  [3][32];
    bit          pend [3][32];
    bit          known = 0;

    typedef struct packed {
        logic [2:0][31:0] d1;
        logic [2:0][31:0] d2;
        logic [2:0]       b1;
        logic [2:0]       b2;
    } obs_t;

    obs_t expq[$];
    int   compared = 0, mismatched = 0, cyc = 0;

    function automatic logic [4:0] ad(input int k, input logic [4:0] a);
        return (cfg_aw[k] == 4) ? {1'b0, a[3:0]} : a;
    endfunction

    task automatic mread(input int k, input logic [4:0] raw, output logic [31:0] d, output logic b);
        logic [4:0] r, a, bb;
        r = ad(k, raw); a = ad(k, wra); bb = ad(k, wrb);
        if (r == 0) begin d = 0; b = 0; end
        else if (cfg_byp[k] != 0 && rst && web && bb != 0 && bb == r) begin d = wdb; b = 0; end
        else if (cfg_byp[k] != 0 && rst && wea && a != 0 && a == r) begin d = wda; b = 0; end
        else begin d = mem[k][r]; b = pend[k][r]; end
    endtask

    task automatic medge();
        logic [4:0] a, bb, ir;
        for (int k = 0; k < 3; k++) begin
            a = ad(k, wra); bb = ad(k, wrb); ir = ad(k, isr);
            if (!rst) begin
                for (int i = 0; i < 32; i++) begin mem[k][i] = 0; pend[k][i] = 0; end
                mem[k][cfg_sp[k]] = 32'h3fc;
            end else begin
                if (wea && a != 0) begin mem[k][a] = wda; pend[k][a] = 0; end
                if (web && bb != 0) begin mem[k][bb] = wdb; pend[k][bb] = 0; end
                if (iss && ir != 0) pend[k][ir] = 1;
            end
        end
        if (!rst) known = 1;
    endtask

    task automatic step(input logic r, input logic a_en, input logic [4:0] a_r, input logic [31:0] a_d,
                        input logic b_en, input logic [4:0] b_r, input logic [31:0] b_d,
                        input logic i_en, input logic [4:0] i_r, input logic [4:0] r1, input logic [4:0] r2);
        obs_t e;
        rst = r; wea = a_en; wra = a_r; wda = a_d; web = b_en; wrb = b_r; wdb = b_d;
        iss = i_en; isr = i_r; rr1 = r1; rr2 = r2;
        if (known) begin
            for (int k = 0; k < 3; k++) begin
                mread(k, rr1, e.d1[k], e.b1[k]);
                mread(k, rr2, e.d2[k], e.b2[k]);
            end
            expq.push_back(e);
        end
        @(posedge clk);
        medge();
        #1;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle with an outstanding expectation, compare all read outputs mid-cycle.
    always @(negedge clk) begin
        obs_t e, a;
        cyc++;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a.d1 = {if4.Read_data1, if0.Read_data1, if1.Read_data1};
            a.d2 = {if4.Read_data2, if0.Read_data2, if1.Read_data2};
            a.b1 = {if4.Busy1, if0.Busy1, if1.Busy1};
            a.b2 = {if4.Busy2, if0.Busy2, if1.Busy2};
            for (int k = 0; k < 3; k++) begin
                check("rd1", k, a.d1[k], e.d1[k]);
                check("rd2", k, a.d2[k], e.d2[k]);
                check("busy1", k, 32'(a.b1[k]), 32'(e.b1[k]));
                check("busy2", k, 32'(a.b2[k]), 32'(e.b2[k]));
            end
        end
    end

    initial begin
        logic a_en, b_en, i_en, r;
        logic [4:0] a_r, b_r, i_r, r1, r2;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 29, 5);
        idle(29, 5);
        idle(3, 0);
        step(1, 1, 0, 32'hdeadbeef, 1, 0, 32'hdeadbeef, 1, 0, 0, 0);
        idle(0, 0);
        step(1, 1, 7, 32'h1111, 1, 7, 32'h2222, 0, 0, 7, 0);
        idle(7, 0);
        step(1, 1, 8, 32'h8888, 1, 9, 32'h9999, 0, 0, 8, 9);
        idle(8, 9);
        step(1, 1, 10, 32'h11, 0, 0, 0, 0, 0, 10, 0);
        step(1, 1, 10, 32'h55, 0, 0, 0, 0, 0, 10, 0);
        idle(10, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
        idle(12, 0);
        idle(12, 0);
        step(1, 1, 12, 32'hc0de, 0, 0, 0, 0, 0, 12, 0);
        idle(12, 0);
        step(1, 0, 0, 0, 1, 12, 32'hbeef, 1, 12, 12, 0);
        idle(12, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
        idle(4, 0);
        step(0, 1, 4, 32'h99, 0, 0, 0, 0, 0, 4, 0);
        idle(4, 0);
        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(0, 39) != 0);
            a_en = $urandom_range(0, 1); b_en = $urandom_range(0, 2) == 0; i_en = $urandom_range(0, 2) == 0;
            a_r = 5'($urandom_range(0, 31)); b_r = 5'($urandom_range(0, 31)); i_r = 5'($urandom_range(0, 31));
            r1 = 5'($urandom_range(0, 31)); r2 = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) b_r = a_r;
            if ($urandom_range(0, 2) == 0) i_r = a_r;
            if ($urandom_range(0, 1) == 0) r1 = a_r;
            if ($urandom_range(0, 1) == 0) r2 = b_r;
            step(r, a_en, a_r, $urandom, b_en, b_r, $urandom, i_en, i_r, r1, r2);
        end
        for (int t = 0; t < 20 && expq.size() > 0; t++) @(posedge clk);
        if (expq.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
